// File: rtl/lcd_line_arbiter_if.sv
// Requester, status and byte-writer signals of lcd_line_arbiter.
// master = arbiter side, slave = requesters plus downstream byte-writer.
`timescale 1ns/1ps
interface lcd_line_arbiter_if;
    logic [1:0] req;
    logic [1:0] line;
    logic [7:0] char0;
    logic [7:0] char1;
    logic [3:0] char_idx;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        input  req, line, char0, char1, wr_ready,
        output char_idx, gnt, done, busy, wr_valid, wr_rs, wr_data
    );

    modport slave (
        output req, line, char0, char1, wr_ready,
        input  char_idx, gnt, done, busy, wr_valid, wr_rs, wr_data
    );
endinterface

// File: rtl/lcd_line_arbiter.sv
// Two-requester LCD line arbiter: runs HD44780 init, then streams set-address + 16 chars per grant.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
`timescale 1ns/1ps
module lcd_line_arbiter #(
    parameter int NREQ     = 2,
    parameter int LINE_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_line_arbiter_if.master  bus
);
    typedef enum logic [2:0] {BOOT, INIT, IDLE, ADDR, DATA, DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            sel_q, sel_d;
    logic            line_q, line_d;
    logic [3:0]      idx_q, idx_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            win;

    logic            wr_valid;
    logic            wr_rs;
    logic [7:0]      wr_data;
    logic [1:0]      done;

`ifdef LCD_ARB_FIXED_PRIO_EN
    always_comb win = ~bus.req[0];
`else
    logic last_q, last_d;

    // last_q resets to 1 so requester 0 wins the first simultaneous request
    always_comb begin
        if (bus.req == 2'b11) win = ~last_q;
        else                  win = bus.req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            gnt_q   <= '0;
            sel_q   <= 1'b0;
            line_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        line_d   = line_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
`ifndef LCD_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = '0;
        done     = '0;

        case (state_q)
            BOOT: begin
                cnt_d   = '0;
                state_d = INIT;
            end
            INIT: begin
                wr_valid = 1'b1;
                case (cnt_q)
                    2'd0:    wr_data = 8'h38;
                    2'd1:    wr_data = 8'h06;
                    2'd2:    wr_data = 8'h0C;
                    default: wr_data = 8'h01;
                endcase
                if (bus.wr_ready) begin
                    if (cnt_q == 2'd3) state_d = IDLE;
                    else               cnt_d   = cnt_q + 2'd1;
                end
            end
            IDLE: begin
                if (|bus.req) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    sel_d      = win;
                    line_d     = bus.line[win];
`ifndef LCD_ARB_FIXED_PRIO_EN
                    last_d     = win;
`endif
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                wr_valid = 1'b1;
                wr_data  = {1'b1, line_q, 6'b0};
                if (bus.wr_ready) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                wr_valid = 1'b1;
                wr_rs    = 1'b1;
                wr_data  = sel_q ? bus.char1 : bus.char0;
                if (bus.wr_ready) begin
                    if (idx_q == 4'(LINE_LEN - 1)) state_d = DONE;
                    else                           idx_d   = idx_q + 4'd1;
                end
            end
            DONE: begin
                done    = gnt_q;
                gnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.wr_valid = wr_valid;
    assign bus.wr_rs    = wr_rs;
    assign bus.wr_data  = wr_data;
    assign bus.done     = done;
    assign bus.gnt      = gnt_q;
    assign bus.char_idx = idx_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
